// File: rtl/change_dispenser.sv
// Coin change dispenser: stores deposited coins of value 1, 2, 5 and 10 and
// pays out a requested amount greedily, one coin per valid/ready handshake.
`timescale 1ns/1ps

module change_dispenser #(
    parameter int COIN_STORAGE_VOLUME = 128,
    parameter int CNT_W               = $clog2(COIN_STORAGE_VOLUME + 1)
) (
    input  logic       clk_i,
    input  logic       hard_areset_n_i,
    input  logic [7:0] slave_data_coin_i,
    input  logic       slave_valid_coin_i,
    output logic       slave_ready_coin_o,
    output logic       coin_reject_o,
    input  logic [7:0] req_amount_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    output logic [7:0] master_data_exchange_o,
    output logic       master_valid_exchange_o,
    input  logic       master_ready_exchange_i,
    output logic       done_o,
    output logic       short_o,
    output logic [7:0] remainder_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(COIN_STORAGE_VOLUME);

    state_t           r_state;
    state_t           w_next_state;

    // Counter index map: 0 -> coin 1, 1 -> coin 2, 2 -> coin 5, 3 -> coin 10.
    logic [CNT_W-1:0] r_cnt [4];
    logic [7:0]       r_remaining;
    logic [7:0]       r_coin;
    logic [1:0]       r_coin_idx;
    logic             r_short;
    logic             r_reject;

    logic             w_idle;
    logic             w_dep_fire;
    logic             w_req_fire;
    logic             w_emit_fire;
    logic             w_dep_known;
    logic [1:0]       w_dep_idx;
    logic             w_dep_store;
    logic             w_dep_reject;
    logic             w_sel_found;
    logic [1:0]       w_sel_idx;
    logic [7:0]       w_sel_coin;

    // Ready is gated by the reset input itself so it reads 0 while reset is
    // held and 1 in the very first cycle after release.
    assign w_idle             = (r_state == IDLE);
    assign slave_ready_coin_o = w_idle & hard_areset_n_i;
    assign req_ready_o        = w_idle & hard_areset_n_i;

    assign w_dep_fire  = slave_valid_coin_i & slave_ready_coin_o;
    assign w_req_fire  = req_valid_i & req_ready_o;
    assign w_emit_fire = master_valid_exchange_o & master_ready_exchange_i;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_dep_known = 1'b1;
        w_dep_idx   = 2'd0;
        case (slave_data_coin_i)
            8'd1:    w_dep_idx = 2'd0;
            8'd2:    w_dep_idx = 2'd1;
            8'd5:    w_dep_idx = 2'd2;
            8'd10:   w_dep_idx = 2'd3;
            default: w_dep_known = 1'b0;
        endcase
    end

    assign w_dep_store  = w_dep_fire & w_dep_known & (r_cnt[w_dep_idx] < MAX_CNT);
    assign w_dep_reject = w_dep_fire & ~w_dep_store;

    // Strictly greedy: largest coin that fits and is in stock, never revisited.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = 2'd0;
        w_sel_coin  = 8'd0;
        if (r_remaining >= 8'd10 && r_cnt[3] != '0) begin
            w_sel_found = 1'b1;
            w_sel_idx   = 2'd3;
            w_sel_coin  = 8'd10;
        end else if (r_remaining >= 8'd5 && r_cnt[2] != '0) begin
            w_sel_found = 1'b1;
            w_sel_idx   = 2'd2;
            w_sel_coin  = 8'd5;
        end else if (r_remaining >= 8'd2 && r_cnt[1] != '0) begin
            w_sel_found = 1'b1;
            w_sel_idx   = 2'd1;
            w_sel_coin  = 8'd2;
        end else if (r_remaining >= 8'd1 && r_cnt[0] != '0) begin
            w_sel_found = 1'b1;
            w_sel_idx   = 2'd0;
            w_sel_coin  = 8'd1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_fire) begin
                    w_next_state = SELECT;
                end
            end
            SELECT: begin
                if (r_remaining == 8'd0 || !w_sel_found) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = EMIT;
                end
            end
            EMIT: begin
                if (master_ready_exchange_i) begin
                    w_next_state = SELECT;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge hard_areset_n_i) begin
        if (!hard_areset_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the coin store is reset explicitly; its contents are architectural
    // state and must read as empty after reset, unlike a scratch RAM.
    always_ff @(posedge clk_i or negedge hard_areset_n_i) begin
        if (!hard_areset_n_i) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_dep_store) begin
                r_cnt[w_dep_idx] <= r_cnt[w_dep_idx] + CNT_W'(1);
            end
            if (w_emit_fire && r_cnt[r_coin_idx] != '0) begin
                r_cnt[r_coin_idx] <= r_cnt[r_coin_idx] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge hard_areset_n_i) begin
        if (!hard_areset_n_i) begin
            r_remaining <= 8'd0;
            r_coin      <= 8'd0;
            r_coin_idx  <= 2'd0;
            r_short     <= 1'b0;
            r_reject    <= 1'b0;
        end else begin
            r_reject <= w_dep_reject;
            if (w_req_fire) begin
                r_remaining <= req_amount_i;
            end else if (w_emit_fire) begin
                r_remaining <= r_remaining - r_coin;
            end
            if (r_state == SELECT) begin
                r_short <= (r_remaining != 8'd0) & ~w_sel_found;
                if (w_sel_found) begin
                    r_coin     <= w_sel_coin;
                    r_coin_idx <= w_sel_idx;
                end
            end
        end
    end

    assign coin_reject_o           = r_reject;
    assign master_valid_exchange_o = (r_state == EMIT);
    assign master_data_exchange_o  = (r_state == EMIT) ? r_coin : 8'd0;
    assign done_o                  = (r_state == DONE);
    assign short_o                 = (r_state == DONE) & r_short;
    assign remainder_o             = (r_state == DONE) ? r_remaining : 8'd0;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random
// deposits/requests compared against a greedy payout model.
`timescale 1ns/1ps

module tb_change_dispenser;

    logic       clk;
    logic       rst_n;
    logic [7:0] slave_data;
    logic       slave_valid;
    logic       slave_ready;
    logic       coin_reject;
    logic [7:0] req_amount;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       done;
    logic       short_flag;
    logic [7:0] remainder;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference store: coin value -> number held.
    int m_store [int];
    int m_exp_coins [$];
    int m_exp_short;
    int m_exp_rem;
    int last_coins [$];
    int last_short;
    int last_rem;

    change_dispenser #(.COIN_STORAGE_VOLUME(128)) dut (
        .clk_i                   (clk),
        .hard_areset_n_i         (rst_n),
        .slave_data_coin_i       (slave_data),
        .slave_valid_coin_i      (slave_valid),
        .slave_ready_coin_o      (slave_ready),
        .coin_reject_o           (coin_reject),
        .req_amount_i            (req_amount),
        .req_valid_i             (req_valid),
        .req_ready_o             (req_ready),
        .master_data_exchange_o  (m_data),
        .master_valid_exchange_o (m_valid),
        .master_ready_exchange_i (m_ready),
        .done_o                  (done),
        .short_o                 (short_flag),
        .remainder_o             (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void model_reset();
        m_store.delete();
        m_store[1]  = 0;
        m_store[2]  = 0;
        m_store[5]  = 0;
        m_store[10] = 0;
    endfunction

    // Returns 1 when the coin would be rejected.
    function automatic int model_deposit(input int v);
        if (!m_store.exists(v)) return 1;
        if (m_store[v] >= 128) return 1;
        m_store[v] = m_store[v] + 1;
        return 0;
    endfunction

    function automatic void model_pay(input int amount);
        int denoms [4] = '{10, 5, 2, 1};
        int rem = amount;
        bit picked;
        m_exp_coins.delete();
        do begin
            picked = 1'b0;
            if (rem > 0) begin
                foreach (denoms[k]) begin
                    if (!picked && denoms[k] <= rem && m_store[denoms[k]] > 0) begin
                        picked = 1'b1;
                        m_store[denoms[k]] = m_store[denoms[k]] - 1;
                        rem = rem - denoms[k];
                        m_exp_coins.push_back(denoms[k]);
                    end
                end
            end
        end while (picked);
        m_exp_short = (rem != 0) ? 1 : 0;
        m_exp_rem   = rem;
    endfunction

    task automatic deposit(input int v);
        int exp_rej;
        @(negedge clk);
        check("reject_pulse_end", coin_reject, 0);
        check("dep_ready", slave_ready, 1);
        slave_valid = 1'b1;
        slave_data  = v[7:0];
        @(negedge clk);
        slave_valid = 1'b0;
        exp_rej = model_deposit(v);
        check($sformatf("coin_reject_v%0d", v), coin_reject, exp_rej[0]);
    endtask

    // Issues a request (optionally with a coin on the same edge) with
    // master ready tied high and checks coins, flags and latency.
    task automatic run_request(input int amount, input int coin);
        int cyc;
        bit done_seen;
        int exp_rej;
        last_coins.delete();
        @(negedge clk);
        check("req_ready", req_ready, 1);
        req_valid  = 1'b1;
        req_amount = amount[7:0];
        if (coin >= 0) begin
            slave_valid = 1'b1;
            slave_data  = coin[7:0];
        end
        @(negedge clk);
        req_valid   = 1'b0;
        slave_valid = 1'b0;
        if (coin >= 0) begin
            exp_rej = model_deposit(coin);
            check("reject_same_edge", coin_reject, exp_rej[0]);
        end
        model_pay(amount);
        done_seen = 1'b0;
        cyc = 1;
        while (!done_seen && cyc < 1000) begin
            if (m_valid) last_coins.push_back(int'(m_data));
            if (done) begin
                done_seen  = 1'b1;
                last_short = int'(short_flag);
                last_rem   = int'(remainder);
                check($sformatf("short_amt%0d", amount), short_flag, m_exp_short[0]);
                check($sformatf("remainder_amt%0d", amount), remainder, m_exp_rem);
                check($sformatf("latency_amt%0d", amount), cyc, 2 + 2 * m_exp_coins.size());
            end else begin
                check("quiet_outputs", {short_flag, remainder, (m_valid ? 8'd0 : m_data)}, 0);
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", done_seen, 1);
        check($sformatf("coin_count_amt%0d", amount), last_coins.size(), m_exp_coins.size());
        if (last_coins.size() == m_exp_coins.size()) begin
            foreach (last_coins[i]) begin
                check($sformatf("coin%0d_amt%0d", i, amount), last_coins[i], m_exp_coins[i]);
            end
        end
        if (done_seen) begin
            @(negedge clk);
            check("done_pulse_end", done, 0);
        end
    endtask

    initial begin
        int cyc;
        int r;
        int v;
        rst_n       = 1'b0;
        slave_data  = 8'd0;
        slave_valid = 1'b0;
        req_amount  = 8'd0;
        req_valid   = 1'b0;
        m_ready     = 1'b1;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_slave_ready", slave_ready, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_outputs", {coin_reject, m_valid, m_data, done, short_flag, remainder}, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_slave_ready", slave_ready, 1);
        check("post_rst_req_ready", req_ready, 1);

        // Greedy exact payout, then empty store
        deposit(10); deposit(5); deposit(2); deposit(1);
        run_request(18, -1);
        check("r18_ncoins", last_coins.size(), 4);
        if (last_coins.size() == 4) begin
            check("r18_c0", last_coins[0], 10);
            check("r18_c3", last_coins[3], 1);
        end
        check("r18_short", last_short, 0);
        run_request(1, -1);
        check("r1_short", last_short, 1);
        check("r1_rem", last_rem, 1);

        // Greedy shortfall with 2s left in stock
        deposit(5); deposit(2); deposit(2); deposit(2);
        run_request(6, -1);
        check("r6a_rem", last_rem, 1);
        run_request(6, -1);
        check("r6b_ncoins", last_coins.size(), 3);
        check("r6b_short", last_short, 0);

        // Unknown coin values
        deposit(3); deposit(7);
        run_request(10, -1);
        check("r10_ncoins", last_coins.size(), 0);
        check("r10_rem", last_rem, 10);

        // Deposit and request on the same edge
        run_request(10, 10);
        check("same_edge_ncoins", last_coins.size(), 1);
        check("same_edge_short", last_short, 0);

        // Storage limit
        for (int i = 0; i < 129; i++) deposit(1);
        run_request(200, -1);
        check("r200_ncoins", last_coins.size(), 128);
        check("r200_rem", last_rem, 72);

        // Back-pressure during EMIT, then reset mid-EMIT
        deposit(2); deposit(2);
        m_ready = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 8'd4;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!m_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_hold_valid%0d", i), m_valid, 1);
            check($sformatf("stall_hold_data%0d", i), m_data, 2);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("after_hs_valid", m_valid, 0);
        @(negedge clk);
        check("second_coin_valid", m_valid, 1);
        check("second_coin_data", m_data, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_drop_valid", m_valid, 0);
        check("rst_drop_ready", req_ready, 0);
        model_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("no_done_after_rst%0d", i), done, 0);
        end
        run_request(1, -1);
        check("post_rst_r1_short", last_short, 1);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 4))
                0: v = 1;
                1: v = 2;
                2: v = 5;
                3: v = 10;
                default: v = $urandom_range(0, 255);
            endcase
            if (r < 6) deposit(v);
            else if (r < 9) run_request($urandom_range(0, 40), -1);
            else run_request($urandom_range(0, 40), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
